x_multdiv: RTL and testbench
============================

# x_multdiv

Execute-stage iterative signed multiply/divide unit. It sits directly downstream of the D/X pipeline latch and consumes that latch's operandA/operandB plus a decoded mult/div start pulse. While an operation is in flight it raises `stall`, which the hazard logic uses to deassert the latch enables and freeze the front of the pipeline. It delivers a 32-bit result with an exception flag, in time for the X/M latch to capture it.

## Interface
Parameters:
- `WIDTH`, 32, operand and result width; the iteration count equals `WIDTH`.

Ports:
- `clock`  in  1  single system clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low; the block is held in reset while low.
- `startMult`  in  1  one-cycle request: signed multiply of `operandA` × `operandB`.
- `startDiv`  in  1  one-cycle request: signed divide of `operandA` ÷ `operandB`.
- `operandA`  in  32  first operand, from the D/X latch.
- `operandB`  in  32  second operand, from the D/X latch.
- `result`  out  32  product (low 32 bits) or quotient; held until the next accepted start.
- `exception`  out  1  overflow or divide-by-zero; held with `result`.
- `resultRdy`  out  1  single-cycle pulse marking `result`/`exception` valid.
- `stall`  out  1  combinational; high while the unit is busy or accepting a start.

## Operation
- States:
  - IDLE: waits for a start request.
  - RUN: iterates; counter `cnt` runs 0..31.
  - DONE: presents the result for one cycle.
- IDLE, `startMult` or `startDiv` high at an edge:
  - Capture operands and operation type.
  - Clear `cnt`.
  - Go to RUN.
- Both starts high together: multiply wins; `startDiv` is ignored.
- Start while in RUN or DONE: ignored; no re-capture.
- Multiply (radix-2 shift-add on magnitudes):
  - 64-bit product register; one partial-product step per RUN cycle.
  - Sign fix-up on the final step.
  - `result` = low 32 bits of the signed product.
  - `exception` = 1 when bits [63:31] of the signed product are not all equal; `result` is then 0.
- Divide (restoring, on magnitudes):
  - One quotient bit per RUN cycle.
  - Quotient is negated when the operand signs differ; truncation is toward zero. The remainder is discarded.
  - `operandB` == 0 at capture: skip RUN and go straight to DONE with `result`=0, `exception`=1.
  - `operandA`=0x80000000 with `operandB`=0xFFFFFFFF: `exception`=1, `result`=0x80000000.
- RUN with `cnt`==31 at an edge: latch `result`/`exception`, go to DONE.
- DONE: `resultRdy`=1; next edge returns to IDLE.
- `stall` = (IDLE & (`startMult` | `startDiv`)) | RUN. It is low in DONE so the pipeline advances on the cycle the result is valid.
- Reset values: state IDLE, `cnt`=0, `result`=0, `exception`=0, `resultRdy`=0, `stall`=0 (inputs permitting), internal operand/product registers 0.
- Reset low mid-operation: the operation is abandoned immediately. No `resultRdy` is produced for it. Outputs return to their reset values asynchronously.

## Timing
- Start sampled at edge E0.
- RUN covers edges E1..E32.
- DONE holds for the cycle after E32; `resultRdy` is high exactly that one cycle. Total latency is 33 cycles from the start edge to result valid.
- Divide-by-zero: DONE after E0; `resultRdy` is high the cycle after E0 (latency 1).
- `stall` is high from the start-request cycle through the last RUN cycle; that is 33 cycles for a normal operation and 1 cycle for divide-by-zero.
- A new start is accepted in the IDLE cycle after DONE. Back-to-back operations therefore have a 34-cycle period.
- `result`/`exception` stay stable after `resultRdy` until the DONE following the next accepted start.

## Test plan
- Multiply 7 × 0xFFFFFFFD (−3): `resultRdy` pulses 33 cycles after start; `result`=0xFFFFFFEB, `exception`=0; `stall` high for exactly 33 cycles.
- Multiply 0x00010000 × 0x00010000: `result`=0, `exception`=1. Then 0xFFFF8000 × 0x00010000: `result`=0x80000000, `exception`=0.
- Divide 0xFFFFFFF9 (−7) ÷ 2: `result`=0xFFFFFFFD, `exception`=0. Also 0x80000000 ÷ 0xFFFFFFFF: `result`=0x80000000, `exception`=1.
- Divide 5 ÷ 0: `resultRdy` high the cycle after start, `result`=0, `exception`=1, `stall` high for 1 cycle only.
- `startDiv` pulsed 10 cycles into a multiply of 3 × 4: the pulse is ignored; `result`=12 at the original latency; no second `resultRdy`.
- `reset` driven low 15 cycles into a divide: all outputs are 0 immediately, no `resultRdy`. After `reset` releases, multiply 2 × 2 returns 4 in 33 cycles.

Source files
------------

// File: rtl/x_multdiv.sv
// x_multdiv -- execute-stage iterative signed multiply/divide unit.
//
// Takes operands from the D/X latch when a one-cycle start request is seen
// in IDLE, then iterates one bit per cycle for WIDTH cycles. A multiply uses
// radix-2 shift-add and a divide uses restoring division. Both work on
// operand magnitudes, and the sign is applied on the final step. The result
// and the exception flag are presented with a one-cycle resultRdy pulse. They
// then hold until the completion of the next accepted operation. stall freezes
// the front of the pipeline from the start-request cycle through the last
// iteration.
//
// Ports:
//   clock      in   system clock, rising-edge
//   reset      in   asynchronous reset, active low
//   startMult  in   one-cycle signed multiply request (wins over startDiv)
//   startDiv   in   one-cycle signed divide request
//   operandA   in   WIDTH-bit first operand (multiplicand / dividend)
//   operandB   in   WIDTH-bit second operand (multiplier / divisor)
//   result     out  low WIDTH bits of the product, or the quotient
//   exception  out  product overflow, quotient overflow or divide-by-zero
//   resultRdy  out  single-cycle pulse, result/exception valid
//   stall      out  combinational busy / accepting indication
module x_multdiv #(
    parameter int WIDTH = 32
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    startMult,
    input  logic                    startDiv,
    input  logic signed [WIDTH-1:0] operandA,
    input  logic signed [WIDTH-1:0] operandB,
    output logic        [WIDTH-1:0] result,
    output logic                    exception,
    output logic                    resultRdy,
    output logic                    stall
);

    localparam int CW = $clog2(WIDTH);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]         r_state;
    logic [CW-1:0]      r_cnt;
    logic               r_isDiv;
    logic               r_negRes;
    logic [WIDTH-1:0]   r_magA;
    logic [WIDTH-1:0]   r_magB;
    // Shared working register:
    //   multiply: {partial product high, remaining multiplier bits}
    //   divide:   {partial remainder, dividend bits shifting into quotient}
    logic [2*WIDTH-1:0] r_prod;
    logic [WIDTH-1:0]   r_result;
    logic               r_exc;

    logic               w_start;
    logic [WIDTH-1:0]   w_magOpA;
    logic [WIDTH-1:0]   w_magOpB;
    logic [WIDTH:0]     w_mulSum;
    logic [2*WIDTH-1:0] w_mulNext;
    logic [2*WIDTH-1:0] w_mulFinal;
    logic [WIDTH:0]     w_divShift;
    logic [WIDTH:0]     w_divDiff;
    logic [2*WIDTH-1:0] w_divNext;

    // Signed product -> {exception, result}. Overflow when the bits above the
    // result's sign bit do not all replicate it; the result is then forced to 0.
    function automatic logic [WIDTH:0] f_mulPack(input logic [2*WIDTH-1:0] p);
        logic [WIDTH:0] upper;
        upper = p[2*WIDTH-1:WIDTH-1];
        if ((&upper) || (~|upper))
            return {1'b0, p[WIDTH-1:0]};
        else
            return {1'b1, {WIDTH{1'b0}}};
    endfunction

    // Quotient magnitude and sign -> {exception, result}. A positive quotient
    // with its top bit set can only be (most-negative / -1). It is flagged,
    // and the result keeps the wrapped bit pattern (most-negative value).
    function automatic logic [WIDTH:0] f_divPack(input logic [WIDTH-1:0] qmag,
                                                 input logic             neg);
        if (neg)
            return {1'b0, -qmag};
        else
            return {qmag[WIDTH-1], qmag};
    endfunction

    assign w_start  = startMult | startDiv;
    // The most-negative value maps to its own bit pattern, which reads
    // correctly as the unsigned magnitude 2^(WIDTH-1).
    assign w_magOpA = operandA[WIDTH-1] ? -operandA : operandA;
    assign w_magOpB = operandB[WIDTH-1] ? -operandB : operandB;

    // Shift-add step: add the multiplicand into the high half when the current
    // multiplier LSB is set, then shift the whole register right by one.
    assign w_mulSum   = {1'b0, r_prod[2*WIDTH-1:WIDTH]} +
                        (r_prod[0] ? {1'b0, r_magA} : {(WIDTH+1){1'b0}});
    assign w_mulNext  = {w_mulSum, r_prod[WIDTH-1:1]};
    assign w_mulFinal = r_negRes ? -w_mulNext : w_mulNext;

    // Restoring step: shift in the next dividend bit and trial-subtract the
    // divisor. A borrow means the subtraction is undone and the quotient bit is 0.
    assign w_divShift = r_prod[2*WIDTH-1:WIDTH-1];
    assign w_divDiff  = w_divShift - {1'b0, r_magB};
    assign w_divNext  = w_divDiff[WIDTH]
                      ? {w_divShift[WIDTH-1:0], r_prod[WIDTH-2:0], 1'b0}
                      : {w_divDiff[WIDTH-1:0],  r_prod[WIDTH-2:0], 1'b1};

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_isDiv  <= 1'b0;
            r_negRes <= 1'b0;
            r_magA   <= '0;
            r_magB   <= '0;
            r_prod   <= '0;
            r_result <= '0;
            r_exc    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_start) begin
                        r_isDiv  <= ~startMult;
                        r_negRes <= operandA[WIDTH-1] ^ operandB[WIDTH-1];
                        r_cnt    <= '0;
                        r_magA   <= w_magOpA;
                        r_magB   <= w_magOpB;
                        r_prod   <= {{WIDTH{1'b0}}, (startMult ? w_magOpB : w_magOpA)};
                        if (!startMult && (operandB == '0)) begin
                            // Divide-by-zero needs no iteration.
                            r_result <= '0;
                            r_exc    <= 1'b1;
                            r_state  <= S_DONE;
                        end else begin
                            r_state  <= S_RUN;
                        end
                    end
                end
                S_RUN: begin
                    r_prod <= r_isDiv ? w_divNext : w_mulNext;
                    r_cnt  <= r_cnt + 1'b1;
                    if (r_cnt == CW'(WIDTH - 1)) begin
                        {r_exc, r_result} <= r_isDiv
                                           ? f_divPack(w_divNext[WIDTH-1:0], r_negRes)
                                           : f_mulPack(w_mulFinal);
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign result    = r_result;
    assign exception = r_exc;
    assign resultRdy = (r_state == S_DONE);
    // Low in DONE so the pipeline advances on the cycle the result is valid.
    assign stall     = ((r_state == S_IDLE) & w_start) | (r_state == S_RUN);

endmodule

// File: tb/tb_x_multdiv.sv
module tb_x_multdiv;

    logic        clock;
    logic        reset;
    logic        startMult;
    logic        startDiv;
    logic [31:0] operandA;
    logic [31:0] operandB;
    logic [31:0] result;
    logic        exception;
    logic        resultRdy;
    logic        stall;

    x_multdiv #(.WIDTH(32)) dut (
        .clock     (clock),
        .reset     (reset),
        .startMult (startMult),
        .startDiv  (startDiv),
        .operandA  (operandA),
        .operandB  (operandB),
        .result    (result),
        .exception (exception),
        .resultRdy (resultRdy),
        .stall     (stall)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [31:0] res;
        logic        exc;
        int          cyc;   // cycle count at which resultRdy must be seen
        int          st;    // stall-high cycles expected for the operation
    } exp_t;

    exp_t        sb[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    int          cyc      = 0;
    int          stall_cnt = 0;
    logic [31:0] hold_res = '0;
    logic        hold_exc = 1'b0;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: plain signed arithmetic on 64-bit integers.
    function automatic logic [32:0] ref_mul(input logic [31:0] a, input logic [31:0] b);
        longint p;
        p = longint'($signed(a)) * longint'($signed(b));
        if (p > 64'sd2147483647 || p < -64'sd2147483648)
            return {1'b1, 32'h0};
        return {1'b0, p[31:0]};
    endfunction

    function automatic logic [32:0] ref_div(input logic [31:0] a, input logic [31:0] b);
        int q;
        if (b == 32'h0)
            return {1'b1, 32'h0};
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
            return {1'b1, 32'h8000_0000};
        q = $signed(a) / $signed(b);
        return {1'b0, q};
    endfunction

    // Monitor: pops and compares on every resultRdy, checks hold otherwise.
    always @(negedge clock) begin
        if (reset) begin
            if (stall) stall_cnt++;
            if (resultRdy) begin
                if (sb.size() == 0) begin
                    chk("unexpected_resultRdy", 64'd1, 64'd0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("result",     64'(result),    64'(e.res));
                    chk("exception",  64'(exception), 64'(e.exc));
                    chk("latency",    64'(cyc),       64'(e.cyc));
                    chk("stall_len",  64'(stall_cnt), 64'(e.st));
                    hold_res = e.res;
                    hold_exc = e.exc;
                end
                stall_cnt = 0;
            end else begin
                chk("hold", {31'h0, exception, result}, {31'h0, hold_exc, hold_res});
            end
        end
    end

    task automatic issue(input bit m, input bit d, input logic [31:0] a, input logic [31:0] b);
        exp_t        e;
        logic [32:0] r;
        int          lat;
        @(posedge clock);
        #1;
        startMult = m;
        startDiv  = d;
        operandA  = a;
        operandB  = b;
        if (m) begin
            r = ref_mul(a, b); lat = 32; e.st = 33;
        end else begin
            r = ref_div(a, b);
            lat  = (b == 32'h0) ? 0 : 32;
            e.st = (b == 32'h0) ? 1 : 33;
        end
        e.res = r[31:0];
        e.exc = r[32];
        @(posedge clock);   // start edge
        #1;
        e.cyc = cyc + lat;
        sb.push_back(e);
        startMult = 1'b0;
        startDiv  = 1'b0;
        operandA  = $urandom;
        operandB  = $urandom;
    endtask

    task automatic drain();
        for (int i = 0; i < 80 && sb.size() != 0; i++) @(posedge clock);
        chk("drain_timeout", 64'(sb.size()), 64'd0);
    endtask

    task automatic op(input bit m, input bit d, input logic [31:0] a, input logic [31:0] b);
        issue(m, d, a, b);
        drain();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a, b;
        bit          m, d;
        reset     = 1'b0;
        startMult = 1'b0;
        startDiv  = 1'b0;
        operandA  = '0;
        operandB  = '0;
        #1;
        chk("rst_result",    64'(result),    64'd0);
        chk("rst_exception", 64'(exception), 64'd0);
        chk("rst_resultRdy", 64'(resultRdy), 64'd0);
        chk("rst_stall",     64'(stall),     64'd0);
        #21;
        reset = 1'b1;

        op(1, 0, 32'd7,          32'hFFFF_FFFD);
        op(1, 0, 32'h0001_0000,  32'h0001_0000);
        op(1, 0, 32'hFFFF_8000,  32'h0001_0000);
        op(0, 1, 32'hFFFF_FFF9,  32'd2);
        op(0, 1, 32'h8000_0000,  32'hFFFF_FFFF);
        op(0, 1, 32'd5,          32'd0);
        op(1, 1, 32'd6,          32'd0);          // both starts: multiply wins
        op(0, 1, 32'h8000_0000,  32'd1);
        op(1, 0, 32'h8000_0000,  32'd1);

        // Start pulse during RUN must be ignored.
        issue(1, 0, 32'd3, 32'd4);
        repeat (10) @(posedge clock);
        #1;
        startDiv = 1'b1;
        operandA = 32'd100;
        operandB = 32'd0;
        @(posedge clock);
        #1;
        startDiv = 1'b0;
        drain();
        repeat (40) @(posedge clock);

        op(1, 0, 32'd9, 32'd9);   // leaves a nonzero result before the reset test

        // Asynchronous reset in the middle of a divide.
        issue(0, 1, 32'd1000, 32'd7);
        repeat (15) @(posedge clock);
        #2;
        reset = 1'b0;
        #1;
        chk("midrst_result",    64'(result),    64'd0);
        chk("midrst_exception", 64'(exception), 64'd0);
        chk("midrst_resultRdy", 64'(resultRdy), 64'd0);
        chk("midrst_stall",     64'(stall),     64'd0);
        sb.delete();
        stall_cnt = 0;
        hold_res  = '0;
        hold_exc  = 1'b0;
        repeat (3) @(posedge clock);
        #3;
        reset = 1'b1;
        op(1, 0, 32'd2, 32'd2);

        for (int i = 0; i < 24; i++) begin
            m = 1'($urandom_range(0, 1));
            d = m ? 1'($urandom_range(0, 1)) : 1'b1;
            a = $signed($urandom) >>> $urandom_range(0, 31);
            b = $signed($urandom) >>> $urandom_range(0, 31);
            if ($urandom_range(0, 7) == 0) b = 32'h0;
            op(m, d, a, b);
        end

        repeat (5) @(posedge clock);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
